mc_control: RTL

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control_pkg.sv | 70 +++++++
 rtl/mc_ctrl_decode.sv | 93 +++++++++
 rtl/mc_control.sv | 112 +++++++++++
 3 files changed

// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle controller: state codes, opcodes,
// datapath select codes and the packed control word driven by the decoder.
package mc_control_pkg;

    // FSM state encodings (also visible on the debug state output)
    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR = 4'd2;
    localparam logic [3:0] ST_MEM_RD   = 4'd3;
    localparam logic [3:0] ST_MEM_WB   = 4'd4;
    localparam logic [3:0] ST_MEM_WR   = 4'd5;
    localparam logic [3:0] ST_R_EXEC   = 4'd6;
    localparam logic [3:0] ST_R_WB     = 4'd7;
    localparam logic [3:0] ST_BRANCH   = 4'd8;
    localparam logic [3:0] ST_JUMP     = 4'd9;
    localparam logic [3:0] ST_ADDI_EX  = 4'd10;
    localparam logic [3:0] ST_ADDI_WB  = 4'd11;

    // Instruction opcodes recognised by the controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_SEXT  = 2'b10;
    localparam logic [1:0] SRCB_SHIFT = 2'b11;

    // Everything the datapath needs from the controller in one cycle
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mdr_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = '0;

    // True for every opcode the FSM knows how to execute
    function automatic logic opcode_is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// State-to-control-word decoder. Purely combinational; the only input besides
// the state is the (already qualified) memory handshake, which gates the
// one-shot load enables in the states that wait on memory.
module mc_ctrl_decode
    import mc_control_pkg::*;
(
    input  logic [3:0]  state_i,
    input  logic        mem_ready_i,
    output ctrl_word_t  ctrl_o
);

    // Control word per state; anything not set stays at zero
    always_comb begin
        ctrl_o = CTRL_IDLE;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.i_or_d    = 1'b0;
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // IR and PC load only on the completing cycle so a stalled
                // fetch does not load them repeatedly
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            ST_DECODE: begin
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_SHIFT;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_SEXT;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
                ctrl_o.mdr_write = mem_ready_i;
            end
            ST_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            ST_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REG;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            ST_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_SEXT;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_ADDI_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle processor control FSM: holds the state register and next-state
// logic, uses mc_ctrl_decode for the per-state control word, and forces every
// output to zero while reset is asserted.
module mc_control
    import mc_control_pkg::*;
#(
    parameter int USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       mem_ready_eff;
    ctrl_word_t ctrl_raw;
    ctrl_word_t ctrl;

    // Without a handshaking memory every access completes in one cycle
    assign mem_ready_eff = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready_eff),
        .ctrl_o      (ctrl_raw)
    );

    // Next-state selection; memory states hold until the access completes
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:    state_d = mem_ready_eff ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE: state_d = ST_R_EXEC;
                    OP_LW:    state_d = ST_MEM_ADDR;
                    OP_SW:    state_d = ST_MEM_ADDR;
                    OP_BEQ:   state_d = ST_BRANCH;
                    OP_J:     state_d = ST_JUMP;
                    OP_ADDI:  state_d = ST_ADDI_EX;
                    default:  state_d = ST_FETCH;
                endcase
            end
            // The IR still holds the opcode here, so it picks load vs store
            ST_MEM_ADDR: state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   state_d = mem_ready_eff ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:   state_d = ST_FETCH;
            ST_MEM_WR:   state_d = mem_ready_eff ? ST_FETCH : ST_MEM_WR;
            ST_R_EXEC:   state_d = ST_R_WB;
            ST_R_WB:     state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JUMP:     state_d = ST_FETCH;
            ST_ADDI_EX:  state_d = ST_ADDI_WB;
            ST_ADDI_WB:  state_d = ST_FETCH;
            default:     state_d = ST_FETCH;
        endcase
    end

    // State register with synchronous reset back to FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset blanks the control word combinationally so nothing fires during
    // reset even if the register still holds a mid-instruction state
    assign ctrl = rst ? CTRL_IDLE : ctrl_raw;

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign ir_write      = ctrl.ir_write;
    assign mdr_write     = ctrl.mdr_write;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign i_or_d        = ctrl.i_or_d;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign instr_done    = ctrl.instr_done;
    assign pc_en         = ctrl.pc_write | (ctrl.pc_write_cond & zero);
    assign illegal_op    = ~rst && (state_q == ST_DECODE) && !opcode_is_legal(opcode);
    assign state         = rst ? ST_FETCH : state_q;

endmodule
